// File: rtl/activation_frame_packer.sv
// Serial-to-frame packer: converts signed samples to the lane Q format with saturation,
// commits NUM lanes at once into the cascade, holds them to settle, then presents them downstream.
module activation_frame_packer #(
   parameter int NUM           = 4,
   parameter int WIDTH         = 16,
   parameter int DECIMAL_POINT = 14,
   parameter int IN_WIDTH      = 16,
   parameter int IN_FRAC       = 8,
   parameter int HOLD_CYCLES   = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   s_valid,
   output logic                   s_ready,
   input  logic [IN_WIDTH-1:0]    s_data,
   input  logic                   s_last,
   output logic [NUM*WIDTH-1:0]   out_signal,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic                   frame_err,
   output logic [15:0]            frame_count
);

   localparam int SH   = DECIMAL_POINT - IN_FRAC;
   localparam int SHL  = (SH > 0) ? SH : 0;
   localparam int SHR  = (SH < 0) ? -SH : 0;
   localparam int EW   = ((IN_WIDTH + SHL > WIDTH) ? IN_WIDTH + SHL : WIDTH) + 1;
   localparam int IDXW = (NUM > 1) ? $clog2(NUM) : 1;
   localparam int HW   = (HOLD_CYCLES > 0) ? $clog2(HOLD_CYCLES + 1) : 1;

   typedef enum logic [1:0] {FILL = 2'd0, HOLD = 2'd1, PRESENT = 2'd2} state_e;

   // Widened so the shift never overflows before the saturation compare.
   function automatic logic [WIDTH-1:0] convert(input logic [IN_WIDTH-1:0] d);
      logic signed [EW-1:0] v;
      logic signed [EW-1:0] max_v;
      logic signed [EW-1:0] min_v;
      logic [WIDTH-1:0]     r;
      v     = {{(EW-IN_WIDTH){d[IN_WIDTH-1]}}, d};
      v     = (v <<< SHL) >>> SHR;
      max_v = {{(EW-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
      min_v = {{(EW-WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};
      if (v > max_v) begin
         r = max_v[WIDTH-1:0];
      end else if (v < min_v) begin
         r = min_v[WIDTH-1:0];
      end else begin
         r = v[WIDTH-1:0];
      end
      return r;
   endfunction

   state_e                       state_q, state_d;
   logic [IDXW-1:0]              idx_q, idx_d;
   logic [HW-1:0]                hold_q, hold_d;
   logic [NUM-1:0][WIDTH-1:0]    shadow_q, shadow_d;
   logic [NUM*WIDTH-1:0]         out_q, out_d;
   logic                         err_q, err_d;
   logic [15:0]                  count_q, count_d;
   logic                         accept_s;
   logic                         end_s;
   logic [WIDTH-1:0]             conv_s;

   assign accept_s = s_valid && (state_q == FILL);
   assign end_s    = accept_s && (s_last || (idx_q == IDXW'(NUM - 1)));
   assign conv_s   = convert(s_data);

   // State and datapath registers
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q  <= FILL;
         idx_q    <= '0;
         hold_q   <= '0;
         shadow_q <= '0;
         out_q    <= '0;
         err_q    <= 1'b0;
         count_q  <= 16'd0;
      end else begin
         state_q  <= state_d;
         idx_q    <= idx_d;
         hold_q   <= hold_d;
         shadow_q <= shadow_d;
         out_q    <= out_d;
         err_q    <= err_d;
         count_q  <= count_d;
      end
   end

   // Next-state logic and hold countdown
   always_comb begin
      state_d = state_q;
      hold_d  = hold_q;
      case (state_q)
         FILL: begin
            if (end_s) begin
               hold_d  = HW'(HOLD_CYCLES);
               state_d = (HOLD_CYCLES == 0) ? PRESENT : HOLD;
            end else begin
               state_d = FILL;
            end
         end
         HOLD: begin
            hold_d = hold_q - HW'(1);
            if (hold_q == HW'(1)) begin
               state_d = PRESENT;
            end else begin
               state_d = HOLD;
            end
         end
         PRESENT: begin
            if (out_ready) begin
               state_d = FILL;
            end else begin
               state_d = PRESENT;
            end
         end
         default: begin
            state_d = FILL;
         end
      endcase
   end

   // Shadow fill, frame commit (zero-padding lanes past the last sample), error and count
   always_comb begin
      idx_d    = idx_q;
      shadow_d = shadow_q;
      out_d    = out_q;
      err_d    = 1'b0;
      count_d  = count_q;
      if (accept_s) begin
         shadow_d[idx_q] = conv_s;
         if (end_s) begin
            idx_d = '0;
            err_d = s_last ^ (idx_q == IDXW'(NUM - 1));
            for (int i = 0; i < NUM; i++) begin
               if (i < int'(idx_q)) begin
                  out_d[i*WIDTH +: WIDTH] = shadow_q[i];
               end else if (i == int'(idx_q)) begin
                  out_d[i*WIDTH +: WIDTH] = conv_s;
               end else begin
                  out_d[i*WIDTH +: WIDTH] = '0;
               end
            end
         end else begin
            idx_d = idx_q + IDXW'(1);
         end
      end else begin
         idx_d = idx_q;
      end
      if ((state_q == PRESENT) && out_ready) begin
         count_d = count_q + 16'd1;
      end else begin
         count_d = count_q;
      end
   end

   // Output decode
   always_comb begin
      s_ready     = (state_q == FILL);
      out_valid   = (state_q == PRESENT);
      out_signal  = out_q;
      frame_err   = err_q;
      frame_count = count_q;
   end

endmodule

// File: tb/tb_activation_frame_packer.sv
// Bench for activation_frame_packer: vector table, randomized frames against a value-level
// model, backpressure, async reset mid-frame, and a HOLD_CYCLES = 0 throughput instance.
module tb_activation_frame_packer;

   localparam int HOLD = 4;
   localparam int SH   = 14 - 8;

   logic        clk = 1'b0;
   logic        rst;
   logic        s_valid, s_ready, s_last, out_valid, out_ready, frame_err;
   logic [15:0] s_data, frame_count;
   logic [63:0] out_signal;

   logic        z_valid, z_ready, z_last, z_out_valid, z_out_ready, z_err;
   logic [15:0] z_data, z_count;
   logic [63:0] z_out;

   int checks = 0;
   int errors = 0;
   int exp_count = 0;

   activation_frame_packer dut (
      .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
      .s_last(s_last), .out_signal(out_signal), .out_valid(out_valid),
      .out_ready(out_ready), .frame_err(frame_err), .frame_count(frame_count)
   );

   activation_frame_packer #(.HOLD_CYCLES(0)) dut0 (
      .clk(clk), .rst(rst), .s_valid(z_valid), .s_ready(z_ready), .s_data(z_data),
      .s_last(z_last), .out_signal(z_out), .out_valid(z_out_valid),
      .out_ready(z_out_ready), .frame_err(z_err), .frame_count(z_count)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [3:0][15:0] smp;
      logic [2:0]       n;
      logic             has_last;
      logic [3:0]       wait_cyc;
      logic [63:0]      exp_out;
      logic             exp_err;
   } vec_t;

   vec_t tbl [6];

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Value-level conversion: scale by 2^SH, floor on right shifts, clamp to 16-bit range.
   function automatic logic [15:0] ref_conv(input logic [15:0] d);
      int x, q, dv;
      x = int'($signed(d));
      if (SH >= 0) begin
         q = x * (1 << SH);
      end else begin
         dv = 1 << (-SH);
         q  = x / dv;
         if ((x % dv != 0) && (x < 0)) q = q - 1;
      end
      if (q > 32767) q = 32767;
      if (q < -32768) q = -32768;
      return q[15:0];
   endfunction

   task automatic run_frame(input vec_t v, input string tag);
      for (int i = 0; i < int'(v.n); i++) begin
         s_valid   = 1'b1;
         s_data    = v.smp[i];
         s_last    = v.has_last && (i == int'(v.n) - 1);
         out_ready = 1'($urandom_range(0, 1));
         chk({tag, "_s_ready_fill"}, s_ready, 1'b1);
         step();
      end
      s_valid = 1'b0;
      s_last  = 1'b0;
      chk({tag, "_frame_err"}, frame_err, v.exp_err);
      chk({tag, "_out_signal"}, out_signal, v.exp_out);
      for (int k = 0; k < HOLD; k++) begin
         chk({tag, "_out_valid_early"}, out_valid, 1'b0);
         out_ready = 1'($urandom_range(0, 1));
         step();
         if (k == 0) chk({tag, "_err_pulse_end"}, frame_err, 1'b0);
      end
      chk({tag, "_out_valid_rise"}, out_valid, 1'b1);
      chk({tag, "_count_before"}, frame_count, 64'(exp_count));
      for (int w = 0; w < int'(v.wait_cyc); w++) begin
         out_ready = 1'b0;
         s_valid   = 1'($urandom_range(0, 1));
         s_data    = 16'($urandom);
         s_last    = 1'($urandom_range(0, 1));
         step();
         chk({tag, "_bp_valid"}, out_valid, 1'b1);
         chk({tag, "_bp_signal"}, out_signal, v.exp_out);
         chk({tag, "_bp_s_ready"}, s_ready, 1'b0);
         chk({tag, "_bp_count"}, frame_count, 64'(exp_count));
      end
      s_valid   = 1'b0;
      s_last    = 1'b0;
      out_ready = 1'b1;
      step();
      exp_count = (exp_count + 1) % 65536;
      out_ready = 1'b0;
      chk({tag, "_hs_valid"}, out_valid, 1'b0);
      chk({tag, "_hs_s_ready"}, s_ready, 1'b1);
      chk({tag, "_hs_count"}, frame_count, 64'(exp_count));
      chk({tag, "_hs_signal_kept"}, out_signal, v.exp_out);
   endtask

   initial begin
      vec_t rv;
      int   acc, cyc;
      logic was_end;

      tbl[0] = '{smp: {16'h0000, 16'h0080, 16'hFF00, 16'h0100}, n: 3'd4, has_last: 1'b1,
                 wait_cyc: 4'd0, exp_out: 64'h0000_2000_C000_4000, exp_err: 1'b0};
      tbl[1] = '{smp: {16'h8001, 16'h7FFF, 16'h8000, 16'h0200}, n: 3'd4, has_last: 1'b1,
                 wait_cyc: 4'd2, exp_out: 64'h8000_7FFF_8000_7FFF, exp_err: 1'b0};
      tbl[2] = '{smp: {16'h5555, 16'h5555, 16'h0100, 16'h0100}, n: 3'd2, has_last: 1'b1,
                 wait_cyc: 4'd1, exp_out: 64'h0000_0000_4000_4000, exp_err: 1'b1};
      tbl[3] = '{smp: {16'h0001, 16'hFFFF, 16'h0040, 16'hFFC0}, n: 3'd4, has_last: 1'b0,
                 wait_cyc: 4'd10, exp_out: 64'h0040_FFC0_1000_F000, exp_err: 1'b1};
      tbl[4] = '{smp: {16'h1111, 16'h2222, 16'h3333, 16'h01FF}, n: 3'd1, has_last: 1'b1,
                 wait_cyc: 4'd0, exp_out: 64'h0000_0000_0000_7FC0, exp_err: 1'b1};
      tbl[5] = '{smp: {16'h7777, 16'hFE00, 16'h0180, 16'hFE01}, n: 3'd3, has_last: 1'b1,
                 wait_cyc: 4'd3, exp_out: 64'h0000_8000_6000_8040, exp_err: 1'b1};

      rst = 1'b0;
      s_valid = 1'b0; s_last = 1'b0; s_data = 16'h0000; out_ready = 1'b0;
      z_valid = 1'b0; z_last = 1'b0; z_data = 16'h0000; z_out_ready = 1'b0;
      repeat (3) step();
      rst = 1'b1;
      step();
      chk("reset_s_ready", s_ready, 1'b1);
      chk("reset_out_valid", out_valid, 1'b0);
      chk("reset_out_signal", out_signal, 64'h0);
      chk("reset_frame_err", frame_err, 1'b0);
      chk("reset_frame_count", frame_count, 64'h0);

      for (int t = 0; t < 6; t++) run_frame(tbl[t], $sformatf("vec%0d", t));

      for (int r = 0; r < 20; r++) begin
         rv.n        = 3'($urandom_range(1, 4));
         rv.has_last = (rv.n < 3'd4) ? 1'b1 : 1'($urandom_range(0, 1));
         rv.wait_cyc = 4'($urandom_range(0, 3));
         rv.exp_out  = 64'h0;
         for (int i = 0; i < 4; i++) begin
            if ($urandom_range(0, 1) == 1) rv.smp[i] = 16'($urandom);
            else rv.smp[i] = 16'($urandom_range(0, 1023) - 512);
            if (i < int'(rv.n)) rv.exp_out[i*16 +: 16] = ref_conv(rv.smp[i]);
         end
         rv.exp_err = (rv.n < 3'd4) || !rv.has_last;
         run_frame(rv, $sformatf("rnd%0d", r));
      end

      // Async reset after two samples of a frame
      s_valid = 1'b1; s_last = 1'b0; s_data = 16'h0100;
      step();
      s_data = 16'h0200;
      step();
      s_valid = 1'b0;
      #2;
      rst = 1'b0;
      #1;
      chk("arst_out_signal", out_signal, 64'h0);
      chk("arst_out_valid", out_valid, 1'b0);
      chk("arst_frame_err", frame_err, 1'b0);
      chk("arst_frame_count", frame_count, 64'h0);
      step();
      rst = 1'b1;
      exp_count = 0;
      step();
      chk("arst_s_ready", s_ready, 1'b1);
      run_frame(tbl[0], "post_rst");

      // HOLD_CYCLES = 0 instance: three back-to-back frames
      z_valid = 1'b1; z_data = 16'h0100; z_out_ready = 1'b1;
      acc = 0; cyc = 0;
      while ((z_count < 16'd3) && (cyc < 60)) begin
         z_last  = ((acc % 4) == 3);
         was_end = z_ready && z_last;
         if (z_ready) acc++;
         step();
         cyc++;
         if (was_end) chk("h0_valid_after_commit", z_out_valid, 1'b1);
      end
      z_valid = 1'b0; z_last = 1'b0;
      chk("h0_cycles", 64'(cyc), 64'd15);
      chk("h0_count", z_count, 64'd3);
      chk("h0_out_signal", z_out, 64'h4000_4000_4000_4000);
      chk("h0_err", z_err, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
